// File: rtl/user_code_loader_if.sv
// user_code_loader_if
//   Write bus between the user-code loader and the user-code BRAM wrapper.
//   master (loader) : drives mem_ce, mem_we, mem_addr, mem_wr_data, mem_byte_sel
//                     and receives mem_ready.
//   slave (wrapper) : the mirror image; pulses mem_ready when a write completes.
interface user_code_loader_if;
  logic        mem_ce;        // chip enable, high for the whole write
  logic        mem_we;        // write enable, high together with mem_ce
  logic [31:0] mem_addr;      // byte address, word aligned
  logic [31:0] mem_wr_data;   // write data, 0 while no write is in flight
  logic [3:0]  mem_byte_sel;  // 4'hF during writes, 4'h0 otherwise
  logic        mem_ready;     // one-cycle write-complete pulse

  modport master (
    output mem_ce, mem_we, mem_addr, mem_wr_data, mem_byte_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_ce, mem_we, mem_addr, mem_wr_data, mem_byte_sel,
    output mem_ready
  );
endinterface

// File: rtl/user_code_loader.sv
// user_code_loader
//   Parses a UART byte stream (4-byte little-endian word count followed by
//   that many little-endian 32-bit words) and writes each word into the
//   user-code BRAM through the wrapper's ce/we/ready handshake. Reports
//   progress, a running checksum and error status to the monitor.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : one-cycle pulses; abort wins over start
//   rx_valid/rx_data: received byte stream
//   mem             : BRAM wrapper write bus (master side)
//   busy, done      : load in progress / one-cycle completion pulse
//   error, err_code : sticky error flag and cause (1 length, 2 overrun, 3 timeout)
//   checksum        : sum mod 2^32 of the words written this load
//   words_written   : completed writes this load
module user_code_loader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned MAX_WORDS     = 16384,
  parameter int unsigned READY_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  user_code_loader_if.master  mem,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [31:0]         checksum,
  output logic [15:0]         words_written
);

  localparam int TW = $clog2(READY_TIMEOUT + 1);

  localparam logic [1:0] ERR_LENGTH  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, LEN, DATA, FINISH} parse_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_GAP} write_state_t;

  parse_state_t  state;
  write_state_t  wstate;
  logic [1:0]    byte_cnt;
  logic [31:0]   length;
  logic [31:0]   asm_word;
  logic [31:0]   pend_word;
  logic [31:0]   pend_addr;
  logic          pending;
  logic [15:0]   word_index;
  logic [TW-1:0] timer;
  // Internal errors are flagged on one edge and torn down on the next, so
  // the bus drops one cycle after error rises.
  logic          kill_q;

  logic [31:0]   len_next;
  logic [31:0]   asm_next;
  logic          write_done;
  logic          pend_free;
  logic          all_words;

  // Bytes arrive LSB first, so each new byte enters at the top and the
  // register shifts down; after four bytes the first one sits in [7:0].
  assign len_next   = {rx_data, length[31:8]};
  assign asm_next   = {rx_data, asm_word[31:8]};
  assign write_done = (wstate == W_ACTIVE) && mem.mem_ready;
  // A word completing this cycle frees the slot for a word arriving now.
  assign pend_free  = !pending || write_done;
  assign all_words  = ({16'd0, word_index} == length);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wstate           <= W_IDLE;
      byte_cnt         <= '0;
      length           <= '0;
      asm_word         <= '0;
      pend_word        <= '0;
      pend_addr        <= '0;
      pending          <= 1'b0;
      word_index       <= '0;
      timer            <= '0;
      kill_q           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      err_code         <= '0;
      checksum         <= '0;
      words_written    <= '0;
      mem.mem_ce       <= 1'b0;
      mem.mem_we       <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_wr_data  <= '0;
      mem.mem_byte_sel <= '0;
    end else if (abort || kill_q) begin
      // Tear down: discard the pending word and release the bus. error and
      // err_code keep whatever the failing path left in them.
      state            <= IDLE;
      wstate           <= W_IDLE;
      pending          <= 1'b0;
      kill_q           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem.mem_ce       <= 1'b0;
      mem.mem_we       <= 1'b0;
      mem.mem_wr_data  <= '0;
      mem.mem_byte_sel <= '0;
    end else begin
      done <= 1'b0;

      // ---------------- write engine ----------------
      unique case (wstate)
        W_IDLE, W_GAP: begin
          // From W_GAP the bus has already been low for one cycle, so a
          // waiting word may be issued straight away.
          if (pending) begin
            mem.mem_ce       <= 1'b1;
            mem.mem_we       <= 1'b1;
            mem.mem_byte_sel <= 4'hF;
            mem.mem_addr     <= pend_addr;
            mem.mem_wr_data  <= pend_word;
            timer            <= '0;
            wstate           <= W_ACTIVE;
          end else begin
            wstate <= W_IDLE;
          end
        end
        W_ACTIVE: begin
          if (mem.mem_ready) begin
            pending          <= 1'b0;
            checksum         <= checksum + mem.mem_wr_data;
            words_written    <= words_written + 16'd1;
            mem.mem_ce       <= 1'b0;
            mem.mem_we       <= 1'b0;
            mem.mem_byte_sel <= 4'h0;
            mem.mem_wr_data  <= '0;
            wstate           <= W_GAP;
          end else if (timer == TW'(READY_TIMEOUT - 1)) begin
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
            kill_q   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase

      // ---------------- parse FSM ----------------
      // NOTE: all state here is assigned non-blocking, so the parser below
      // sees pre-edge values, and when it sets pending on the same edge the
      // write engine clears it, the later assignment (set) is the one kept.
      unique case (state)
        IDLE: begin
          if (start) begin
            checksum      <= '0;
            words_written <= '0;
            error         <= 1'b0;
            err_code      <= '0;
            busy          <= 1'b1;
            byte_cnt      <= '0;
            word_index    <= '0;
            state         <= LEN;
          end
        end
        LEN: begin
          if (rx_valid) begin
            length   <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (len_next == 32'd0) begin
                state <= FINISH;
              end else if (len_next > 32'(MAX_WORDS)) begin
                error    <= 1'b1;
                err_code <= ERR_LENGTH;
                busy     <= 1'b0;
                state    <= IDLE;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (all_words) begin
            if (!pending && wstate == W_IDLE) state <= FINISH;
          end else if (rx_valid) begin
            asm_word <= asm_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (pend_free) begin
                pend_word  <= asm_next;
                pend_addr  <= BASE_ADDR + {14'd0, word_index, 2'b00};
                pending    <= 1'b1;
                word_index <= word_index + 16'd1;
              end else begin
                error    <= 1'b1;
                err_code <= ERR_OVERRUN;
                kill_q   <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
